// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_pkg
// Description : Shared types and constants for the set-associative BTB.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

    // Widest supported address; entry fields are stored zero-extended to this.
    localparam int BTB_AW_MAX = 64;

    localparam logic [1:0] CTR_WEAK_T = 2'b10;
    localparam logic [1:0] CTR_MAX    = 2'b11;
    localparam logic [1:0] CTR_MIN    = 2'b00;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } btb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            ctr;
        logic [BTB_AW_MAX-1:0] tag;
        logic [BTB_AW_MAX-1:0] target;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == CTR_MAX) ? CTR_MAX : c + 2'd1;
        end
        return (c == CTR_MIN) ? CTR_MIN : c - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_set_lookup.sv
`default_nettype none
// ============================================================================
// Module      : btb_set_lookup
// Description : Tag compare and way select for one fetch slot of the BTB.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_set_lookup
    import btb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  logic                         en,
    input  logic [ADDR_WIDTH-1:0]        pc,
    input  btb_entry_t [WAYS-1:0]        ways,
    output logic                         hit,
    output logic                         taken,
    output logic [ADDR_WIDTH-1:0]        target
);

    localparam int IDX_W = $clog2(SETS);

    logic [BTB_AW_MAX-1:0] w_tag;
    btb_entry_t            w_sel;
    logic                  w_match;
    logic                  w_unused_sel;

    assign w_tag = BTB_AW_MAX'(pc[ADDR_WIDTH-1:IDX_W+2]);

    // Tags are unique within a set; scanning downward keeps the lowest way.
    always_comb begin
        w_match = 1'b0;
        w_sel   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (ways[w].valid && (ways[w].tag == w_tag)) begin
                w_match = 1'b1;
                w_sel   = ways[w];
            end
        end
    end

    assign hit          = en && w_match;
    assign taken        = hit && w_sel.ctr[1];
    assign target       = taken ? w_sel.target[ADDR_WIDTH-1:0] : pc + ADDR_WIDTH'(4);
    assign w_unused_sel = ^w_sel;

endmodule
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
// Module      : btb_assoc
// Description : Set-associative branch target buffer with chained multi-slot
//               lookup, 2-bit counters and a whole-table invalidate sweep.
//               Define BTB_STATS_EN to add slot-0 hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_assoc
    import btb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int SETS        = 16,
    parameter int WAYS        = 2,
    parameter int FETCH_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_WIDTH-1:0]             pc,
    input  logic                              pc_valid,
    output logic [FETCH_WIDTH-1:0]            predict_taken,
    output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] predict_target,
    input  logic                              upd_valid,
    input  logic [ADDR_WIDTH-1:0]             upd_pc,
    input  logic [ADDR_WIDTH-1:0]             upd_target,
    input  logic                              upd_taken,
    input  logic                              inv_req,
    output logic                              busy
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]                       lookup_hits,
    output logic [31:0]                       lookup_misses
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int VIC_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    btb_entry_t [WAYS-1:0]   r_tab [SETS];
    logic [VIC_W-1:0]        r_vict [SETS];
    btb_state_e              r_state;
    logic [IDX_W-1:0]        r_sweep_idx;

    logic                    w_look_en;
    logic [FETCH_WIDTH-1:0]  w_slot_hit;
    logic                    w_unused_hits;
    logic [1:0]              w_unused_upd_lo;

    assign busy      = (r_state == ST_SWEEP);
    assign w_look_en = pc_valid && !busy;

    // Each slot after the first looks up the predicted next PC of its predecessor.
    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
        logic [ADDR_WIDTH-1:0] w_pc;
        logic [ADDR_WIDTH-1:0] w_tgt;
        logic                  w_taken;
        logic                  w_hit;

        if (k == 0) begin : g_head
            assign w_pc = pc;
        end else begin : g_tail
            assign w_pc = g_slot[k-1].w_tgt;
        end

        btb_set_lookup #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .SETS       (SETS),
            .WAYS       (WAYS)
        ) u_lookup (
            .en     (w_look_en),
            .pc     (w_pc),
            .ways   (r_tab[w_pc[IDX_W+1:2]]),
            .hit    (w_hit),
            .taken  (w_taken),
            .target (w_tgt)
        );

        assign predict_taken[k]                            = w_taken;
        assign predict_target[k*ADDR_WIDTH +: ADDR_WIDTH]  = w_tgt;
        assign w_slot_hit[k]                               = w_hit;
    end

    assign w_unused_hits   = ^w_slot_hit;
    assign w_unused_upd_lo = upd_pc[1:0];

    // ------------------------------------------------------------------
    // Update path: hit detection, free-way search and allocation choice
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic [VIC_W-1:0] w_upd_hit_way;
    logic             w_upd_has_free;
    logic [VIC_W-1:0] w_free_way;
    logic [VIC_W-1:0] w_alloc_way;
    logic [VIC_W-1:0] w_vict_next;

    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[ADDR_WIDTH-1:IDX_W+2];

    always_comb begin
        w_upd_hit      = 1'b0;
        w_upd_hit_way  = '0;
        w_upd_has_free = 1'b0;
        w_free_way     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_tab[w_upd_idx][w].valid &&
                (r_tab[w_upd_idx][w].tag == BTB_AW_MAX'(w_upd_tag))) begin
                w_upd_hit     = 1'b1;
                w_upd_hit_way = VIC_W'(w);
            end
            if (!r_tab[w_upd_idx][w].valid) begin
                w_upd_has_free = 1'b1;
                w_free_way     = VIC_W'(w);
            end
        end
    end

    assign w_alloc_way = w_upd_has_free ? w_free_way : r_vict[w_upd_idx];
    assign w_vict_next = (r_vict[w_upd_idx] == VIC_W'(WAYS - 1)) ? '0
                                                                 : r_vict[w_upd_idx] + 1'b1;

    // ------------------------------------------------------------------
    // Table state and invalidate sweep
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sweep_idx <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_tab[s]  <= '0;
                r_vict[s] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (inv_req) begin
                        r_state     <= ST_SWEEP;
                        r_sweep_idx <= '0;
                    end
                    if (upd_valid) begin
                        if (w_upd_hit) begin
                            r_tab[w_upd_idx][w_upd_hit_way].ctr <=
                                ctr_step(r_tab[w_upd_idx][w_upd_hit_way].ctr, upd_taken);
                            if (upd_taken) begin
                                r_tab[w_upd_idx][w_upd_hit_way].target <= BTB_AW_MAX'(upd_target);
                            end
                        end else if (upd_taken) begin
                            r_tab[w_upd_idx][w_alloc_way] <= '{valid:  1'b1,
                                                                ctr:    CTR_WEAK_T,
                                                                tag:    BTB_AW_MAX'(w_upd_tag),
                                                                target: BTB_AW_MAX'(upd_target)};
                            if (!w_upd_has_free) begin
                                r_vict[w_upd_idx] <= w_vict_next;
                            end
                        end
                    end
                end
                ST_SWEEP: begin
                    r_tab[r_sweep_idx]  <= '0;
                    r_vict[r_sweep_idx] <= '0;
                    r_sweep_idx         <= r_sweep_idx + 1'b1;
                    if (r_sweep_idx == IDX_W'(SETS - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_hits   <= '0;
            lookup_misses <= '0;
        end else if (w_look_en) begin
            if (w_slot_hit[0]) begin
                lookup_hits <= lookup_hits + 32'd1;
            end else begin
                lookup_misses <= lookup_misses + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_assoc
// Description : Directed self-checking bench for btb_assoc (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  predict_taken;
    logic [63:0] predict_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        inv_req;
    logic        busy;
`ifdef BTB_STATS_EN
    logic [31:0] lookup_hits;
    logic [31:0] lookup_misses;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btb_assoc #(
        .ADDR_WIDTH  (32),
        .SETS        (16),
        .WAYS        (2),
        .FETCH_WIDTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .inv_req        (inv_req),
        .busy           (busy)
`ifdef BTB_STATS_EN
        ,
        .lookup_hits    (lookup_hits),
        .lookup_misses  (lookup_misses)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic tk);
        upd_valid  = 1'b1;
        upd_pc     = a;
        upd_target = t;
        upd_taken  = tk;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] a, input logic pv,
                        input logic t0, input logic [31:0] g0,
                        input logic t1, input logic [31:0] g1);
        pc       = a;
        pc_valid = pv;
        #1;
        check({tag, ".tk0"}, 32'(predict_taken[0]), 32'(t0));
        check({tag, ".tg0"}, predict_target[31:0], g0);
        check({tag, ".tk1"}, 32'(predict_taken[1]), 32'(t1));
        check({tag, ".tg1"}, predict_target[63:32], g1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst = 1'b1; pc = '0; pc_valid = 1'b0; upd_valid = 1'b0;
        upd_pc = '0; upd_target = '0; upd_taken = 1'b0; inv_req = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        look("rst_look", 32'h100, 1'b1, 1'b0, 32'h104, 1'b0, 32'h108);

        // Allocate and hit, slot 1 chains off slot 0's target
        upd(32'h100, 32'h200, 1'b1);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h204);
        look("pcv0", 32'h100, 1'b0, 1'b0, 32'h104, 1'b0, 32'h108);

        // Counter saturation at 0 then recovery
        repeat (4) upd(32'h100, 32'h200, 1'b0);
        look("sat0", 32'h100, 1'b1, 1'b0, 32'h104, 1'b0, 32'h108);
        upd(32'h100, 32'h200, 1'b1);
        look("ctr1", 32'h100, 1'b1, 1'b0, 32'h104, 1'b0, 32'h108);
        upd(32'h100, 32'h250, 1'b1);
        look("ctr2", 32'h100, 1'b1, 1'b1, 32'h250, 1'b0, 32'h254);

        // Two-way set conflict: third allocation evicts the first
        upd(32'h140, 32'h500, 1'b1);
        upd(32'h180, 32'h600, 1'b1);
        look("evict100", 32'h100, 1'b1, 1'b0, 32'h104, 1'b0, 32'h108);
        look("keep140", 32'h140, 1'b1, 1'b1, 32'h500, 1'b0, 32'h504);
        look("keep180", 32'h180, 1'b1, 1'b1, 32'h600, 1'b0, 32'h604);

        // Same-cycle update and lookup: no bypass
        upd_valid = 1'b1; upd_pc = 32'h300; upd_target = 32'h700; upd_taken = 1'b1;
        look("nobypass", 32'h300, 1'b1, 1'b0, 32'h304, 1'b0, 32'h308);
        tick();
        upd_valid = 1'b0;
        look("after_upd", 32'h300, 1'b1, 1'b1, 32'h700, 1'b0, 32'h704);
        look("evict140", 32'h140, 1'b1, 1'b0, 32'h144, 1'b0, 32'h148);
        look("keep180b", 32'h180, 1'b1, 1'b1, 32'h600, 1'b0, 32'h604);

        // Not-taken miss must not allocate
        upd(32'h400, 32'h990, 1'b0);
        look("nt_miss", 32'h400, 1'b1, 1'b0, 32'h404, 1'b0, 32'h408);
        look("keep300", 32'h300, 1'b1, 1'b1, 32'h700, 1'b0, 32'h704);

        // Entry in the last set, cleared at the end of the sweep
        upd(32'h13C, 32'h900, 1'b1);
        look("set15", 32'h13C, 1'b1, 1'b1, 32'h900, 1'b0, 32'h904);
        look("set15_pcv0", 32'h13C, 1'b0, 1'b0, 32'h140, 1'b0, 32'h144);

        // Invalidate sweep
        inv_req = 1'b1;
        tick();
        inv_req = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (cnt == 2) look("busy_look", 32'h13C, 1'b1, 1'b0, 32'h140, 1'b0, 32'h144);
            if (cnt == 3) begin
                upd_valid = 1'b1; upd_pc = 32'h800; upd_target = 32'hA00; upd_taken = 1'b1;
            end
            if (cnt == 5) inv_req = 1'b1;
            tick();
            upd_valid = 1'b0;
            inv_req   = 1'b0;
        end
        check("sweep_len", 32'(cnt), 32'd16);
        look("post180", 32'h180, 1'b1, 1'b0, 32'h184, 1'b0, 32'h188);
        look("post13C", 32'h13C, 1'b1, 1'b0, 32'h140, 1'b0, 32'h144);
        look("post800", 32'h800, 1'b1, 1'b0, 32'h804, 1'b0, 32'h808);

        // Reset in the middle of a sweep
        upd(32'h13C, 32'h900, 1'b1);
        look("re13C", 32'h13C, 1'b1, 1'b1, 32'h900, 1'b0, 32'h904);
        inv_req = 1'b1;
        tick();
        inv_req = 1'b0;
        tick(); tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_abort", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_idle", 32'(busy), 32'd0);
        look("rst13C", 32'h13C, 1'b1, 1'b0, 32'h140, 1'b0, 32'h144);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning PC/target width.
REQ-002 SHALL have parameter SETS, default 16, meaning set count (power of 2, >=2).
REQ-003 SHALL have parameter WAYS, default 2, meaning associativity (power of 2, >=1).
REQ-004 SHALL have parameter FETCH_WIDTH, default 2, meaning predictions per cycle (>=1).
REQ-005 SHALL have port clk, input, 1, meaning the clock.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port pc, input, ADDR_WIDTH, meaning the fetch PC of slot 0.
REQ-008 SHALL have port pc_valid, input, 1, meaning the lookup is requested.
REQ-009 SHALL have port predict_taken, output, FETCH_WIDTH, meaning the per-slot taken prediction.
REQ-010 SHALL have port predict_target, output, FETCH_WIDTH*ADDR_WIDTH, meaning the per-slot next PC, with slot k in bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port upd_valid, input, 1, meaning a retired branch update.
REQ-012 SHALL have ports upd_pc and upd_target, each input, ADDR_WIDTH, meaning the branch PC and its resolved target.
REQ-013 SHALL have port upd_taken, input, 1, meaning the resolved direction.
REQ-014 SHALL have port inv_req, input, 1, meaning a request to invalidate the whole table.
REQ-015 SHALL have port busy, output, 1, meaning an invalidate sweep is in progress.

Function
REQ-016 Indexing SHALL use idx = addr[$clog2(SETS)+1:2] and tag = addr[ADDR_WIDTH-1:$clog2(SETS)+2].
REQ-017 Each entry SHALL hold valid, tag, target, and a 2-bit saturating counter; each set SHALL hold a victim pointer of width $clog2(WAYS).
REQ-018 Lookup SHALL be combinational: slot 0 uses pc; slot k+1 uses the predict_target of slot k.
REQ-019 A slot SHALL be taken iff some way has valid, a matching tag, and counter[1]=1; its target is then that way's target, otherwise pc_k+4.
REQ-020 If pc_valid=0 or busy=1, every slot SHALL be not-taken, with target = previous slot's target (or pc for slot 0) + 4.
REQ-021 Updates SHALL be written at the posedge after upd_valid; a lookup in the same cycle SHALL see the pre-update contents (no bypass).
REQ-022 An update hit SHALL increment the counter (saturating at 3) if taken and decrement it (saturating at 0) otherwise; the target SHALL be overwritten only when taken.
REQ-023 An update miss with upd_taken=1 SHALL allocate the lowest-index invalid way, or the victim way if all ways are valid, set counter=2'b10, and advance the victim pointer modulo WAYS only when the victim way was used.
REQ-024 An update miss with upd_taken=0 SHALL NOT allocate.
REQ-025 The sweep FSM SHALL have states IDLE and SWEEP; inv_req in IDLE SHALL go to SWEEP, clearing set 0 on the first cycle and set SETS-1 on the last, for SETS cycles, then return to IDLE.
REQ-026 busy SHALL be 1 exactly while in SWEEP; inv_req in SWEEP SHALL be ignored; upd_valid in SWEEP SHALL be dropped.

Reset
REQ-027 rst SHALL clear all valid bits, counters, and victim pointers; the FSM SHALL go to IDLE and busy SHALL be 0.
REQ-028 rst during SWEEP SHALL abort the sweep, and the table SHALL be fully cleared.

Configuration
REQ-029 With BTB_STATS_EN defined, the block SHALL add 32-bit outputs lookup_hits and lookup_misses, counting slot-0 tag hits and misses when pc_valid=1 and busy=0, wrapping at 2^32, and reset to 0; without BTB_STATS_EN, those ports and their logic SHALL be absent.

Structure
REQ-030 Package btb_pkg SHALL hold the entry struct typedef, the counter constants (CTR_WEAK_T=2'b10, CTR_MAX=2'b11), and the FSM state enum.
REQ-031 Sub-module btb_set_lookup SHALL perform one slot's tag compare and way select, and SHALL be instantiated FETCH_WIDTH times.

Verification
REQ-032 Update pc=0x100, taken, target=0x200, then lookup pc=0x100 -> slot0 taken with target 0x200, and slot1 looks up 0x200 -> not taken with target 0x204.
REQ-033 Four not-taken updates at 0x100 after allocation -> the counter saturates at 0 and the lookup returns not-taken with target 0x104; two taken updates -> taken again.
REQ-034 With WAYS=2, allocate three PCs 0x100/0x140/0x180 sharing a set -> 0x100 is evicted and the other two hit.
REQ-035 Same-cycle update of 0x300 and lookup of 0x300 -> that cycle is not-taken, and the next cycle is taken.
REQ-036 inv_req -> busy is high for exactly SETS cycles, and all subsequent lookups miss; an upd_valid issued mid-sweep is not retained.
REQ-037 rst asserted mid-sweep -> busy=0 on the next cycle, and all entries are invalid.
